// File: rtl/sb_axi_mem_responder.sv
// Purpose: AXI4 subordinate backed by an on-chip array of 512-bit words; stands in for host memory.
// Latency: write beats accepted 1/cycle, B one cycle after last W; first R beat 2 cycles after AR, then 1 beat per 2 cycles.
// Backpressure: single outstanding burst per direction; B and R outputs are held stable until bready/rready.
//
// Ports:
//   clk, nreset             clock and asynchronous active-low reset
//   s_axi_aw*/w*/b*         write address, write data and write response channels
//   s_axi_ar*/r*            read address and read data channels
//   awuser/aruser are accepted but carry no meaning here.
module sb_axi_mem_responder #(
    parameter int unsigned MEM_WORDS_LOG2 = 10,
    parameter logic [63:0] BASE_ADDR      = 64'h0
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [15:0]  s_axi_awid,
    input  logic [63:0]  s_axi_awaddr,
    input  logic [7:0]   s_axi_awlen,
    input  logic [2:0]   s_axi_awsize,
    input  logic [18:0]  s_axi_awuser,
    input  logic         s_axi_awvalid,
    output logic         s_axi_awready,
    input  logic [511:0] s_axi_wdata,
    input  logic [63:0]  s_axi_wstrb,
    input  logic         s_axi_wlast,
    input  logic         s_axi_wvalid,
    output logic         s_axi_wready,
    output logic [15:0]  s_axi_bid,
    output logic [1:0]   s_axi_bresp,
    output logic         s_axi_bvalid,
    input  logic         s_axi_bready,
    input  logic [15:0]  s_axi_arid,
    input  logic [63:0]  s_axi_araddr,
    input  logic [7:0]   s_axi_arlen,
    input  logic [2:0]   s_axi_arsize,
    input  logic [18:0]  s_axi_aruser,
    input  logic         s_axi_arvalid,
    output logic         s_axi_arready,
    output logic [15:0]  s_axi_rid,
    output logic [511:0] s_axi_rdata,
    output logic [1:0]   s_axi_rresp,
    output logic         s_axi_rlast,
    output logic         s_axi_rvalid,
    input  logic         s_axi_rready
);
    localparam int unsigned WORDS = 1 << MEM_WORDS_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

    logic [511:0] mem_q [WORDS];

    // User sideband has no meaning for a plain memory.
    logic unused_user;
    assign unused_user = ^{s_axi_awuser, s_axi_aruser};

    // ---------------------------------------------------------------- write side
    w_state_t    w_state_q, w_state_d;
    logic [15:0] w_id_q, w_id_d;
    logic [63:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic        w_err_q, w_err_d;

    logic [63:0]               w_off;
    logic                      w_in_range;
    logic [MEM_WORDS_LOG2-1:0] w_word;
    logic                      w_last_beat;
    logic                      mem_we;

    // Subtraction wraps for addresses below the base, so they fail the range test too.
    assign w_off       = w_addr_q - BASE_ADDR;
    assign w_in_range  = (w_off >> (MEM_WORDS_LOG2 + 6)) == 64'd0;
    assign w_word      = w_off[6 +: MEM_WORDS_LOG2];
    assign w_last_beat = (w_cnt_q == w_len_q);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    w_id_d    = s_axi_awid;
                    w_addr_d  = s_axi_awaddr;
                    w_len_d   = s_axi_awlen;
                    w_size_d  = s_axi_awsize;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we = w_in_range;
                    if (!w_in_range || (s_axi_wlast != w_last_beat)) begin
                        w_err_d = 1'b1;
                    end
                    // The beat count from AW decides the burst length, not wlast.
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d  = w_cnt_q + 8'd1;
                        w_addr_d = w_addr_q + (64'd1 << w_size_q);
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 64; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[w_word][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi_awready = nreset && (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = ((w_state_q == W_RESP) && w_err_q) ? 2'b10 : 2'b00;

    // ----------------------------------------------------------------- read side
    r_state_t    r_state_q, r_state_d;
    logic [15:0] r_id_q, r_id_d;
    logic [63:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [2:0]  r_size_q, r_size_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic        r_ok_q, r_ok_d;
    logic [511:0] r_word_q;

    logic [63:0]               r_off;
    logic                      r_in_range;
    logic [MEM_WORDS_LOG2-1:0] r_word;

    assign r_off      = r_addr_q - BASE_ADDR;
    assign r_in_range = (r_off >> (MEM_WORDS_LOG2 + 6)) == 64'd0;
    assign r_word     = r_off[6 +: MEM_WORDS_LOG2];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_cnt_q   <= '0;
            r_ok_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_cnt_q   <= r_cnt_d;
            r_ok_q    <= r_ok_d;
        end
    end

    // Array read port: sampled only in R_FETCH so the beat stays stable while R stalls.
    // A write to the same word on the same edge is not yet visible (read-first).
    always_ff @(posedge clk) begin
        if (r_state_q == R_FETCH) begin
            r_word_q <= mem_q[r_word];
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_cnt_d   = r_cnt_q;
        r_ok_d    = r_ok_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_id_d    = s_axi_arid;
                    r_addr_d  = s_axi_araddr;
                    r_len_d   = s_axi_arlen;
                    r_size_d  = s_axi_arsize;
                    r_cnt_d   = '0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                r_ok_d    = r_in_range;
                r_state_d = R_SEND;
            end
            R_SEND: begin
                if (s_axi_rready) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_addr_d  = r_addr_q + (64'd1 << r_size_q);
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // r_ok_q resets low, which also forces rdata to zero out of reset.
    assign s_axi_arready = nreset && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_SEND);
    assign s_axi_rid     = r_id_q;
    assign s_axi_rdata   = r_ok_q ? r_word_q : '0;
    assign s_axi_rresp   = ((r_state_q == R_SEND) && !r_ok_q) ? 2'b10 : 2'b00;
    assign s_axi_rlast   = (r_state_q == R_SEND) && (r_cnt_q == r_len_q);

endmodule

// File: tb/tb_sb_axi_mem_responder.sv
`timescale 1ns/1ps
module tb_sb_axi_mem_responder;
    localparam int          L         = 10;
    localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MEM_BYTES = 64'd1 << (L + 6);

    logic         clk = 1'b0;
    logic         nreset;
    logic [15:0]  s_axi_awid;
    logic [63:0]  s_axi_awaddr;
    logic [7:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [18:0]  s_axi_awuser;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [511:0] s_axi_wdata;
    logic [63:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [15:0]  s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [15:0]  s_axi_arid;
    logic [63:0]  s_axi_araddr;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [18:0]  s_axi_aruser;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [15:0]  s_axi_rid;
    logic [511:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;

    always #5 clk = ~clk;

    sb_axi_mem_responder #(.MEM_WORDS_LOG2(L), .BASE_ADDR(BASE)) dut (
        .clk(clk), .nreset(nreset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awuser(s_axi_awuser), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_aruser(s_axi_aruser), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference memory: what each word must hold after every completed write.
    logic [511:0] ref_mem [0:(1<<L)-1];
    // Beat payloads for the next write burst.
    logic [511:0] wd [0:255];
    logic [63:0]  ws [0:255];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic axi_write(input logic [63:0] addr, input int len, input logic [2:0] size,
                             input bit early_last, input string tag);
        logic [15:0] id;
        logic [63:0] a, off;
        bit          rdy, exp_err, lastv;
        int          guard;
        id            = 16'($urandom);
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awsize  = size;
        s_axi_awvalid = 1'b1;
        guard = 0;
        do begin rdy = s_axi_awready; tick(); guard++; end while (!rdy && guard < 20);
        s_axi_awvalid = 1'b0;
        chk({tag, " aw_accept"}, 512'(rdy), 512'd1);
        exp_err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            lastv        = early_last ? (i == 0) : (i == len);
            s_axi_wdata  = wd[i];
            s_axi_wstrb  = ws[i];
            s_axi_wlast  = lastv;
            s_axi_wvalid = 1'b1;
            guard = 0;
            do begin rdy = s_axi_wready; tick(); guard++; end while (!rdy && guard < 20);
            chk({tag, " w_accept"}, 512'(rdy), 512'd1);
            a   = addr + 64'(i) * (64'd1 << size);
            off = a - BASE;
            if (off < MEM_BYTES) begin
                for (int b = 0; b < 64; b++)
                    if (ws[i][b]) ref_mem[off[6 +: L]][b*8 +: 8] = wd[i][b*8 +: 8];
            end else begin
                exp_err = 1'b1;
            end
            if (lastv != (i == len)) exp_err = 1'b1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        chk({tag, " bvalid"}, 512'(s_axi_bvalid), 512'd1);
        chk({tag, " bid"}, 512'(s_axi_bid), 512'(id));
        chk({tag, " bresp"}, 512'(s_axi_bresp), exp_err ? 512'd2 : 512'd0);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        chk({tag, " awready_after_b"}, 512'(s_axi_awready), 512'd1);
    endtask

    task automatic axi_read(input logic [63:0] addr, input int len, input logic [2:0] size,
                            input int stall_beat, input string tag);
        logic [15:0]  id;
        logic [63:0]  a, off;
        logic [511:0] exp_d;
        bit           rdy, ok;
        int           guard;
        id            = 16'($urandom);
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arsize  = size;
        s_axi_arvalid = 1'b1;
        guard = 0;
        do begin rdy = s_axi_arready; tick(); guard++; end while (!rdy && guard < 20);
        s_axi_arvalid = 1'b0;
        chk({tag, " ar_accept"}, 512'(rdy), 512'd1);
        for (int i = 0; i <= len; i++) begin
            // Exactly one fetch cycle precedes every beat.
            guard = 0;
            while (!s_axi_rvalid && guard < 10) begin tick(); guard++; end
            chk({tag, " r_gap"}, 512'(guard), 512'd1);
            a     = addr + 64'(i) * (64'd1 << size);
            off   = a - BASE;
            ok    = off < MEM_BYTES;
            exp_d = ok ? ref_mem[off[6 +: L]] : '0;
            chk({tag, " rvalid"}, 512'(s_axi_rvalid), 512'd1);
            chk({tag, " rid"}, 512'(s_axi_rid), 512'(id));
            chk({tag, " rdata"}, s_axi_rdata, exp_d);
            chk({tag, " rresp"}, 512'(s_axi_rresp), ok ? 512'd0 : 512'd2);
            chk({tag, " rlast"}, 512'(s_axi_rlast), 512'(i == len));
            if (i == stall_beat) begin
                repeat (3) begin
                    tick();
                    chk({tag, " stall_rvalid"}, 512'(s_axi_rvalid), 512'd1);
                    chk({tag, " stall_rdata"}, s_axi_rdata, exp_d);
                end
            end
            s_axi_rready = 1'b1;
            tick();
            s_axi_rready = 1'b0;
        end
        chk({tag, " arready_after"}, 512'(s_axi_arready), 512'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] old_d, new_d;
        logic [63:0]  addr, low;
        logic [2:0]   size;
        int           len, stall;

        nreset        = 1'b0;
        s_axi_awid    = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awuser  = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_arid    = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_aruser  = '0; s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;

        // Reset values while nreset is held low.
        #2;
        chk("rst awready", 512'(s_axi_awready), 512'd0);
        chk("rst arready", 512'(s_axi_arready), 512'd0);
        chk("rst wready", 512'(s_axi_wready), 512'd0);
        chk("rst bvalid", 512'(s_axi_bvalid), 512'd0);
        chk("rst rvalid", 512'(s_axi_rvalid), 512'd0);
        chk("rst rlast", 512'(s_axi_rlast), 512'd0);
        chk("rst bid_rid", 512'({s_axi_bid, s_axi_rid}), 512'd0);
        chk("rst resp", 512'({s_axi_bresp, s_axi_rresp}), 512'd0);
        chk("rst rdata", s_axi_rdata, 512'd0);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        #1;
        chk("rel awready", 512'(s_axi_awready), 512'd1);
        chk("rel arready", 512'(s_axi_arready), 512'd1);

        // Fill words 0..31 so every later read has a known expectation.
        for (int i = 0; i < 32; i++) begin wd[i] = rand512(); ws[i] = '1; end
        axi_write(BASE, 31, 3'd6, 1'b0, "prefill");
        axi_read(BASE, 31, 3'd6, -1, "prefill_rd");

        // Single beat write then read.
        wd[0] = rand512(); ws[0] = '1;
        axi_write(BASE + 64'h40, 0, 3'd6, 1'b0, "single_wr");
        axi_read(BASE + 64'h40, 0, 3'd6, -1, "single_rd");

        // Four-beat burst, read back with a stall on the second beat.
        for (int i = 0; i < 4; i++) begin wd[i] = rand512(); ws[i] = '1; end
        axi_write(BASE, 3, 3'd6, 1'b0, "burst_wr");
        axi_read(BASE, 3, 3'd6, 1, "burst_rd");

        // Byte strobes: only the low 8 bytes of word 5 are cleared.
        wd[0] = '1; ws[0] = '1;
        axi_write(BASE + 64'd5 * 64, 0, 3'd6, 1'b0, "strb_ones");
        wd[0] = '0; ws[0] = 64'h0000_0000_0000_00FF;
        axi_write(BASE + 64'd5 * 64, 0, 3'd6, 1'b0, "strb_low");
        chk("strb model", ref_mem[5], {{56{8'hFF}}, 64'h0});
        axi_read(BASE + 64'd5 * 64, 0, 3'd6, -1, "strb_rd");

        // Out-of-range accesses, above the array and below the base.
        wd[0] = rand512(); ws[0] = '1;
        axi_write(BASE + 64'h10000, 0, 3'd6, 1'b0, "oor_wr");
        axi_read(BASE, 0, 3'd6, -1, "oor_no_alias");
        axi_read(BASE + 64'h10000, 0, 3'd6, -1, "oor_rd_hi");
        axi_read(BASE - 64'h40, 0, 3'd6, -1, "oor_rd_lo");
        // Burst straddling the top word: first beat lands, second is dropped.
        wd[0] = rand512(); wd[1] = rand512(); ws[0] = '1; ws[1] = '1;
        axi_write(BASE + 64'd1023 * 64, 1, 3'd6, 1'b0, "straddle_wr");
        axi_read(BASE + 64'd1023 * 64, 1, 3'd6, -1, "straddle_rd");

        // Early wlast: two beats still taken, response flags the error.
        wd[0] = rand512(); wd[1] = rand512(); ws[0] = '1; ws[1] = '1;
        axi_write(BASE + 64'd10 * 64, 1, 3'd6, 1'b1, "early_last");
        axi_read(BASE + 64'd10 * 64, 1, 3'd6, -1, "early_last_rd");

        // Randomized mix of reads and writes, including narrow sizes.
        for (int t = 0; t < 30; t++) begin
            size = 3'($urandom_range(0, 6));
            len  = int'($urandom_range(0, 7));
            low  = 64'($urandom_range(0, 63));
            addr = BASE + 64'($urandom_range(0, 24)) * 64 + low;
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= len; i++) begin wd[i] = rand512(); ws[i] = {$urandom, $urandom}; end
                axi_write(addr, len, size, 1'b0, "rand_wr");
            end else begin
                if ($urandom_range(0, 5) == 0) addr = BASE - 64'($urandom_range(8, 100)) * 64;
                stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
                axi_read(addr, len, size, stall, "rand_rd");
            end
        end

        // AW and AR accepted together; the write and the fetch of word 7 share an edge.
        old_d = ref_mem[7];
        new_d = rand512();
        s_axi_awid = 16'h1234; s_axi_awaddr = BASE + 64'd7 * 64; s_axi_awlen = 8'd0; s_axi_awsize = 3'd6;
        s_axi_arid = 16'h5678; s_axi_araddr = BASE + 64'd7 * 64; s_axi_arlen = 8'd0; s_axi_arsize = 3'd6;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        s_axi_wdata = new_d; s_axi_wstrb = '1; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        chk("conc awready", 512'(s_axi_awready), 512'd1);
        chk("conc arready", 512'(s_axi_arready), 512'd1);
        tick();
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        chk("conc wready", 512'(s_axi_wready), 512'd1);
        chk("conc rvalid_fetch", 512'(s_axi_rvalid), 512'd0);
        tick();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        chk("conc rvalid", 512'(s_axi_rvalid), 512'd1);
        chk("conc rdata_old", s_axi_rdata, old_d);
        chk("conc rid", 512'(s_axi_rid), 512'h5678);
        chk("conc bvalid", 512'(s_axi_bvalid), 512'd1);
        chk("conc bid", 512'(s_axi_bid), 512'h1234);
        chk("conc bresp", 512'(s_axi_bresp), 512'd0);
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        tick();
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        ref_mem[7] = new_d;
        axi_read(BASE + 64'd7 * 64, 0, 3'd6, -1, "conc_after");

        // Reset in the middle of a read burst.
        s_axi_arid = 16'h0042; s_axi_araddr = BASE; s_axi_arlen = 8'd3; s_axi_arsize = 3'd6;
        chk("mid arready", 512'(s_axi_arready), 512'd1);
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        tick();
        chk("mid beat0", 512'(s_axi_rvalid), 512'd1);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        tick();
        chk("mid beat1", 512'(s_axi_rvalid), 512'd1);
        nreset = 1'b0;
        #1;
        chk("mid rst rvalid", 512'(s_axi_rvalid), 512'd0);
        chk("mid rst rlast", 512'(s_axi_rlast), 512'd0);
        chk("mid rst arready", 512'(s_axi_arready), 512'd0);
        chk("mid rst rid", 512'(s_axi_rid), 512'd0);
        chk("mid rst rdata", s_axi_rdata, 512'd0);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        #1;
        chk("post arready", 512'(s_axi_arready), 512'd1);
        chk("post rvalid", 512'(s_axi_rvalid), 512'd0);
        axi_read(BASE + 64'h40, 1, 3'd6, -1, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sb_axi_mem_responder.md
Name: sb_axi_mem_responder

Overview:
- AXI4 subordinate memory that answers the 512-bit AXI manager port of the FPGA queue block. It stands in for host memory in FPGA-side simulation and loopback builds.
- The queue engine's reads and writes of queue memory land in an on-chip word array.
- Write and read channels run independently, with a single outstanding transaction per direction.
- Only INCR bursts are supported, since the manager carries no burst-type signal.

Parameters:
MEM_WORDS_LOG2, 10, log2 of the number of 64-byte words in the backing array.
BASE_ADDR, 64'h0, byte address that maps to word 0.

Ports:
clk  input  1  clock
nreset  input  1  asynchronous active-low reset
s_axi_awid  input  16  write ID
s_axi_awaddr  input  64  write byte address
s_axi_awlen  input  8  beats minus one
s_axi_awsize  input  3  log2 bytes per beat (0..6)
s_axi_awuser  input  19  ignored
s_axi_awvalid  input  1  AW valid
s_axi_awready  output  1  AW ready
s_axi_wdata  input  512  write data
s_axi_wstrb  input  64  byte strobes
s_axi_wlast  input  1  last write beat
s_axi_wvalid  input  1  W valid
s_axi_wready  output  1  W ready
s_axi_bid  output  16  echoed awid
s_axi_bresp  output  2  write response
s_axi_bvalid  output  1  B valid
s_axi_bready  input  1  B ready
s_axi_arid  input  16  read ID
s_axi_araddr  input  64  read byte address
s_axi_arlen  input  8  beats minus one
s_axi_arsize  input  3  log2 bytes per beat
s_axi_aruser  input  19  ignored
s_axi_arvalid  input  1  AR valid
s_axi_arready  output  1  AR ready
s_axi_rid  output  16  echoed arid
s_axi_rdata  output  512  read data
s_axi_rresp  output  2  read response
s_axi_rlast  output  1  last read beat
s_axi_rvalid  output  1  R valid
s_axi_rready  input  1  R ready

Behaviour:
- Reset (nreset low, asynchronous): write FSM goes to W_IDLE, read FSM goes to R_IDLE.
  - awready=arready=1 (deasserted while nreset is low); wready=bvalid=rvalid=rlast=0.
  - bid=rid=0, bresp=rresp=0, rdata=0.
  - Array contents are not reset.
  - Reset mid-burst abandons the transaction with no response; words already written stay written.
- Address mapping: off = addr - BASE_ADDR (64-bit). word = off[6 +: MEM_WORDS_LOG2].
  - A beat is in range iff off < 2^(MEM_WORDS_LOG2+6), evaluated as unsigned, so addr < BASE_ADDR is out of range.
- Beat address: per-beat byte address advances by 2^size after each beat. No 4KB-boundary checking.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, latch id, addr, len, size; clear the beat counter and error flag; go to W_DATA.
  - W_DATA: wready=1. On each W handshake:
    - In range: write array bytes where wstrb=1; others are unchanged.
    - Out of range: drop the data and set the error flag.
    - If wlast != (count==len), set the error flag.
    - When count==len, go to W_RESP regardless of wlast; otherwise increment count and the address.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if error else 2'b00. Hold until bready; on the handshake go to W_IDLE.
  - awready returns the cycle after the B handshake.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, latch fields and go to R_FETCH.
  - R_FETCH (1 cycle): registered array read of the current word. Go to R_SEND.
  - R_SEND: rvalid=1, rid=latched id, rlast=(count==len).
    - In range: rdata = word, rresp=00. Out of range: rdata=0, rresp=2'b10.
    - Outputs are held stable until rready.
    - On the handshake: if last, go to R_IDLE; else increment count and address and go to R_FETCH.
- Latency and throughput:
  - First rvalid comes 2 cycles after AR acceptance; one read beat per 2 cycles at best.
  - Writes: one beat per cycle; bvalid comes the cycle after the last W handshake.
- Simultaneous read and write of the same word in the same cycle: the read returns old data (read-first).
- Both AW and AR accepted in the same cycle: both proceed independently.
- Narrow sizes (<6): data is still taken/returned on the full 512-bit lanes. The manager positions the bytes; the subordinate honours only wstrb.

Test Plan:
- Single write then read: AW addr=BASE+0x40, len=0, size=6, wstrb=all-ones, data=D → bresp=00, bid echoed. AR same address → rdata=D, rresp=00, rlast=1, rvalid 2 cycles after AR handshake.
- Burst: write len=3 at BASE with data W0..W3, then read len=3 → four R beats W0..W3, rlast only on the 4th, rid echoed. Stall rready for 3 cycles on beat 2 → rdata/rvalid held stable.
- Strobes: write all-ones to word 5, then write zeros with wstrb=64'h0000_0000_0000_00FF → read gives low 8 bytes 0, remaining bytes 0xFF.
- Out of range: MEM_WORDS_LOG2=10, write at BASE+0x10000 → bresp=10 and no aliasing into word 0. Read there → rdata=0, rresp=10. Read at BASE-0x40 → rresp=10.
- Protocol error: len=1 with wlast on the first beat → FSM still takes 2 beats, bresp=10.
- Concurrency and reset: write and read bursts overlapping the same word → read returns pre-write data when same-cycle. Assert nreset mid read burst → rvalid=0 immediately, arready=1 after release, and a new read completes normally.
